spi_slave_fsm: RTL and testbench
================================

// Module: spi_slave_fsm
// PURPOSE
//  SPI slave front end. Deserialises MOSI frames into 10-bit words for the RAM stage (spi_ram) via rx_data/rx_valid.
//  On read-data frames it waits for the RAM's tx_data/tx_valid and serialises the byte MSB-first on MISO.
//  Single clock domain: clk is the SPI serial clock. MOSI is sampled and MISO driven on rising clk.
// PARAMETERS
//  RX_WIDTH  10  frame word width to RAM; bits [9:8] are the command field.
//  TX_WIDTH   8  read-data width from RAM.
// PORTS
//  clk        in   1         clock (SPI SCK), rising edge
//  rst_n      in   1         reset, asynchronous, active-low
//  SS_n       in   1         slave select, active-low; high aborts or ends a frame
//  MOSI       in   1         serial data in, MSB first
//  MISO       out  1         serial data out, MSB first
//  rx_data    out  RX_WIDTH  assembled frame word to RAM
//  rx_valid   out  1         one-cycle strobe: rx_data is valid
//  tx_data    in   TX_WIDTH  read byte from RAM
//  tx_valid   in   1         tx_data is valid (level or pulse; sampled in READ_DATA only)
//  frame_err  out  1         only when SPI_SLAVE_ERR_EN is defined; see CONFIGURATION
// BEHAVIOUR
//  Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, bit counter=0, rd_addr_seen=0, tx shift reg=0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  - IDLE: SS_n=0 -> CHK_CMD on the next edge. No bit is sampled in IDLE; this is a one-cycle dummy.
//  - CHK_CMD: sample MOSI as rx bit 9 and shift it in.
//      MOSI=0 -> WRITE; MOSI=1 & !rd_addr_seen -> READ_ADD; MOSI=1 & rd_addr_seen -> READ_DATA.
//  - WRITE/READ_ADD/READ_DATA: shift in the remaining 9 bits, one per cycle.
//      The edge that captures bit 0 registers rx_data and sets rx_valid=1 for exactly one cycle.
//      Latency: rx_valid is high in the cycle after the 10th MOSI sample.
//  - rx_data is forwarded unmodified; the RAM decodes [9:8]. The FSM branches on bit 9 only.
//  - READ_ADD completion (rx_valid) sets rd_addr_seen=1. READ_DATA completion of the TX byte clears it.
//  - WRITE/READ_ADD: after rx_valid, hold until SS_n=1, then go to IDLE. Further MOSI bits are ignored.
//  - READ_DATA, after rx_valid:
//      wait for tx_valid=1, latch tx_data into the TX shift register,
//      then drive MISO = bits 7..0 on the following 8 consecutive cycles, MSB first,
//      then MISO=0 and hold until SS_n=1.
//      tx_valid before rx_valid, or after the byte is latched, is ignored. No timeout: wait until SS_n=1.
//  - SS_n=1 in any state -> IDLE on the next edge (priority over all else), with:
//      counter cleared, MISO=0, no rx_valid issued for a partial frame, TX byte discarded;
//      rd_addr_seen unchanged, except it is cleared if all 8 TX bits were shifted out.
//  - SS_n=1 on the same edge the 10th bit would be sampled: frame aborted, no rx_valid.
//  - Counter counts 0..9 RX and 0..7 TX, then saturates; no wrap-around.
//  - Reset mid-frame: immediate return to reset values; rx_valid drops asynchronously.
// CONFIGURATION
//  SPI_SLAVE_ERR_EN defined:
//    frame_err port exists; it pulses for one cycle, registered, when SS_n rises before rx_valid of the current frame,
//    or before all 8 TX bits in READ_DATA. Reset 0.
//  SPI_SLAVE_ERR_EN undefined: no frame_err port, no error logic; all other behaviour identical.
// STRUCTURE
//  Package spi_slave_pkg contains:
//    state enum typedef spi_state_t (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
//    constants RX_WIDTH_C=10, TX_WIDTH_C=8;
//    command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
//  Sub-module spi_tx_serializer:
//    function: load on tx_valid, 8-bit MSB-first shift out, done flag;
//    owns the TX shift register and TX bit count.
//  FSM, RX shift register and rd_addr_seen live in the top module.
// TESTING
//  1. Write addr: SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, single rx_valid 11 cycles after SS_n fall; MISO stays 0.
//  2. Write data: MOSI 01_1111_0000 -> rx_data=10'h1F0, one rx_valid; rd_addr_seen stays 0.
//  3. Read sequence:
//     - frame 10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1;
//     - next frame 11_xxxx_xxxx, then tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on 8 cycles after latch;
//     - rd_addr_seen=0 afterwards.
//  4. Abort: SS_n rises after 6 bits of a WRITE frame -> no rx_valid, IDLE next cycle;
//     next full frame decodes correctly; frame_err=1 for one cycle when SPI_SLAVE_ERR_EN is defined.
//  5. Reset during READ_DATA shift-out (after bit 3) -> MISO=0, rx_valid=0, rd_addr_seen=0 immediately;
//     the next frame starting with 1 goes to READ_ADD.
//  6. tx_valid held high throughout READ_ADD and WRITE frames -> ignored; MISO stays 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end (spi_slave_fsm).
package spi_slave_pkg;

    localparam int RX_WIDTH_C = 10;
    localparam int TX_WIDTH_C = 8;

    // Command field carried in frame bits [9:8]; the RAM stage decodes it.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

    function automatic logic [RX_WIDTH_C-1:0] make_frame(input logic [1:0] cmd,
                                                         input logic [7:0] payload);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// SPI pins plus the RAM-side handshake of spi_slave_fsm.
// Optional frame_err signal exists only when SPI_SLAVE_ERR_EN is defined.
interface spi_slave_fsm_if
    import spi_slave_pkg::*;
#(
    parameter int RX_WIDTH = RX_WIDTH_C,
    parameter int TX_WIDTH = TX_WIDTH_C
) ();

    logic                SS_n;
    logic                MOSI;
    logic                MISO;
    logic [RX_WIDTH-1:0] rx_data;
    logic                rx_valid;
    logic [TX_WIDTH-1:0] tx_data;
    logic                tx_valid;

`ifdef SPI_SLAVE_ERR_EN
    logic                frame_err;

    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid, frame_err);
    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid, frame_err);
`else
    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid);
    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid);
`endif

endinterface

// File: rtl/spi_tx_serializer.sv
// Read-data serializer: loads one byte on tx_valid, shifts it out MSB-first on MISO.
module spi_tx_serializer
    import spi_slave_pkg::*;
#(
    parameter int TX_WIDTH = TX_WIDTH_C
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load_en,
    input  logic                tx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    output logic                miso,
    output logic                all_sent
);

    localparam int               CNT_W    = $clog2(TX_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TX_WIDTH - 1);

    // The MSB goes straight to MISO at load, so only the remaining bits are stored.
    logic [TX_WIDTH-2:0] sreg;
    logic [CNT_W-1:0]    cnt;
    logic                busy;
    logic                done;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is reset too; its contents reach MISO and must be defined.
            sreg <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            miso <= 1'b0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            miso <= 1'b0;
        end else if (busy) begin
            if (cnt == LAST_BIT) begin
                miso <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                miso <= sreg[TX_WIDTH-2];
                sreg <= {sreg[TX_WIDTH-3:0], 1'b0};
                cnt  <= cnt + 1'b1;
            end
        end else if (load_en && tx_valid && !done) begin
            miso <= tx_data[TX_WIDTH-1];
            sreg <= tx_data[TX_WIDTH-2:0];
            cnt  <= '0;
            busy <= 1'b1;
        end
    end

    // The last bit counts as sent while it is on the wire.
    assign all_sent = done | (busy & (cnt == LAST_BIT));

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames for the RAM and serialises read data on MISO.
// Define SPI_SLAVE_ERR_EN to add the frame_err abort indicator.
module spi_slave_fsm
    import spi_slave_pkg::*;
#(
    parameter int RX_WIDTH = RX_WIDTH_C,
    parameter int TX_WIDTH = TX_WIDTH_C
) (
    input logic            clk,
    input logic            rst_n,
    spi_slave_fsm_if.slave bus
);

    localparam int               CNT_W   = $clog2(RX_WIDTH);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_WIDTH - 1);

    spi_state_t          state, state_next;
    logic [CNT_W-1:0]    rx_cnt, rx_cnt_next;
    logic [RX_WIDTH-2:0] rx_shift, rx_shift_next;
    logic [RX_WIDTH-1:0] rx_data_q, rx_data_next;
    logic                rx_valid_q, rx_valid_next;
    logic                rx_done, rx_done_next;
    logic                rd_addr_seen, rd_seen_next;
    logic                tx_all_sent;
    logic                tx_miso;
`ifdef SPI_SLAVE_ERR_EN
    logic                frame_err_q, frame_err_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_cnt       <= '0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            rx_cnt       <= rx_cnt_next;
            rx_shift     <= rx_shift_next;
            rx_data_q    <= rx_data_next;
            rx_valid_q   <= rx_valid_next;
            rx_done      <= rx_done_next;
            rd_addr_seen <= rd_seen_next;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_q  <= frame_err_next;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next    = state;
        rx_cnt_next   = rx_cnt;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data_q;
        rx_valid_next = 1'b0;
        rx_done_next  = rx_done;
        rd_seen_next  = rd_addr_seen;
`ifdef SPI_SLAVE_ERR_EN
        frame_err_next = 1'b0;
`endif
        if (bus.SS_n) begin
            // Deselect wins over everything; a completed read byte still retires the address.
            state_next    = IDLE;
            rx_cnt_next   = '0;
            rx_shift_next = '0;
            rx_done_next  = 1'b0;
            if (tx_all_sent) rd_seen_next = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_next = (state != IDLE) &&
                             (!rx_done || (state == READ_DATA && !tx_all_sent));
`endif
        end else begin
            case (state)
                IDLE: state_next = CHK_CMD;
                CHK_CMD: begin
                    rx_shift_next = {rx_shift[RX_WIDTH-3:0], bus.MOSI};
                    rx_cnt_next   = CNT_W'(1);
                    if (bus.MOSI) state_next = rd_addr_seen ? READ_DATA : READ_ADD;
                    else          state_next = WRITE;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!rx_done) begin
                        rx_shift_next = {rx_shift[RX_WIDTH-3:0], bus.MOSI};
                        if (rx_cnt == RX_LAST) begin
                            rx_data_next  = {rx_shift, bus.MOSI};
                            rx_valid_next = 1'b1;
                            rx_done_next  = 1'b1;
                            if (state == READ_ADD) rd_seen_next = 1'b1;
                        end else begin
                            rx_cnt_next = rx_cnt + 1'b1;
                        end
                    end else if (state == READ_DATA && tx_all_sent) begin
                        rd_seen_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    spi_tx_serializer #(
        .TX_WIDTH (TX_WIDTH)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.SS_n),
        .load_en  ((state == READ_DATA) && rx_done),
        .tx_valid (bus.tx_valid),
        .tx_data  (bus.tx_data),
        .miso     (tx_miso),
        .all_sent (tx_all_sent)
    );

    assign bus.MISO     = tx_miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_ERR_EN
    assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: frame table, rx_data scoreboard, read/abort/reset sequences.
module tb_spi_slave_fsm;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_slave_fsm_if bus ();

    spi_slave_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [RX_WIDTH_C-1:0] exp_q[$];
    logic prev_rx_valid = 1'b0;
    logic miso_hi;
    logic rxv_early;
    logic [7:0] tx_byte;
    logic [9:0] w;

    typedef struct {
        string      name;
        logic [9:0] frame;
        logic       txv;
        logic       exp_seen;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = f[9-i];
            tick();
        end
    endtask

    task automatic end_frame(input string name);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
        check({name, "_idle"}, dut.state, IDLE);
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (prev_rx_valid) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_valid_width: got a second consecutive rx_valid cycle, required one at %0t", $time);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data=0x%0h, required none at %0t",
                         bus.rx_data, $time);
            end else begin
                check("rx_data", bus.rx_data, exp_q.pop_front());
            end
        end
        prev_rx_valid = bus.rx_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"wr_addr",     make_frame(CMD_WR_ADDR, 8'hA5), 1'b0, 1'b0};
        vecs[1] = '{"wr_data_txv", make_frame(CMD_WR_DATA, 8'hF0), 1'b1, 1'b0};
        vecs[2] = '{"rd_addr",     make_frame(CMD_RD_ADDR, 8'h03), 1'b0, 1'b1};
        vecs[3] = '{"wr_addr_txv", make_frame(CMD_WR_ADDR, 8'hC3), 1'b1, 1'b1};

        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) tick();
        check("rst_miso",     bus.MISO, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data",  bus.rx_data, 0);
        check("rst_state",    dut.state, IDLE);
        check("rst_seen",     dut.rd_addr_seen, 0);
`ifdef SPI_SLAVE_ERR_EN
        check("rst_frame_err", bus.frame_err, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Table of complete frames, optionally with tx_valid held high (must be ignored).
        for (int k = 0; k < 4; k++) begin
            bus.SS_n     = 1'b0;
            bus.tx_valid = vecs[k].txv;
            bus.tx_data  = 8'h99;
            miso_hi      = 1'b0;
            rxv_early    = 1'b0;
            tick();
            exp_q.push_back(vecs[k].frame);
            for (int i = 0; i < 10; i++) begin
                bus.MOSI  = vecs[k].frame[9-i];
                miso_hi   = miso_hi | bus.MISO;
                rxv_early = rxv_early | bus.rx_valid;
                tick();
            end
            check({vecs[k].name, "_rx_valid"}, bus.rx_valid, 1);
            check({vecs[k].name, "_rx_early"}, rxv_early, 0);
            for (int i = 0; i < 4; i++) begin
                miso_hi = miso_hi | bus.MISO;
                tick();
                if (i == 0) check({vecs[k].name, "_rx_valid_drop"}, bus.rx_valid, 0);
            end
            check({vecs[k].name, "_miso_quiet"}, miso_hi, 0);
            check({vecs[k].name, "_seen"}, dut.rd_addr_seen, vecs[k].exp_seen);
            bus.tx_valid = 1'b0;
            end_frame(vecs[k].name);
`ifdef SPI_SLAVE_ERR_EN
            check({vecs[k].name, "_frame_err"}, bus.frame_err, 0);
`endif
            tick();
        end

        // Read data: tx_valid before rx_valid is ignored, then 0xC3 is shifted out MSB-first.
        bus.SS_n     = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h5A;
        tick();
        exp_q.push_back(make_frame(CMD_RD_DATA, 8'h5A));
        send_bits(make_frame(CMD_RD_DATA, 8'h5A), 10);
        bus.tx_valid = 1'b0;
        check("rd_data_state", dut.state, READ_DATA);
        check("rd_data_rx_valid", bus.rx_valid, 1);
        miso_hi = bus.MISO;
        repeat (2) begin
            tick();
            miso_hi = miso_hi | bus.MISO;
        end
        check("rd_data_early_tx_ignored", miso_hi, 0);
        tx_byte      = 8'hC3;
        bus.tx_valid = 1'b1;
        bus.tx_data  = tx_byte;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rd_data_miso_bit%0d", 7 - i), bus.MISO, tx_byte[7-i]);
            tick();
        end
        check("rd_data_miso_after", bus.MISO, 0);
        check("rd_data_seen_clear", dut.rd_addr_seen, 0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        miso_hi      = 1'b0;
        repeat (3) begin
            tick();
            miso_hi = miso_hi | bus.MISO;
        end
        check("rd_data_late_tx_ignored", miso_hi, 0);
        bus.tx_valid = 1'b0;
        end_frame("rd_data");
`ifdef SPI_SLAVE_ERR_EN
        check("rd_data_frame_err", bus.frame_err, 0);
`endif
        tick();

        // Abort after 6 bits of a write frame.
        bus.SS_n = 1'b0;
        tick();
        send_bits(make_frame(CMD_WR_ADDR, 8'hF0), 6);
        bus.SS_n = 1'b1;
        tick();
        check("abort6_state", dut.state, IDLE);
        check("abort6_rx_valid", bus.rx_valid, 0);
`ifdef SPI_SLAVE_ERR_EN
        check("abort6_frame_err", bus.frame_err, 1);
`endif
        tick();
        check("abort6_rx_valid_later", bus.rx_valid, 0);
`ifdef SPI_SLAVE_ERR_EN
        check("abort6_frame_err_pulse", bus.frame_err, 0);
`endif

        // A full frame after the abort must decode cleanly.
        bus.SS_n = 1'b0;
        tick();
        exp_q.push_back(make_frame(CMD_WR_DATA, 8'hA5));
        send_bits(make_frame(CMD_WR_DATA, 8'hA5), 10);
        check("post_abort_rx_valid", bus.rx_valid, 1);
        end_frame("post_abort");
        tick();

        // SS_n rises on the edge that would sample bit 0.
        w = make_frame(CMD_WR_ADDR, 8'h3C);
        bus.SS_n = 1'b0;
        tick();
        send_bits(w, 9);
        bus.MOSI = w[0];
        bus.SS_n = 1'b1;
        tick();
        check("abort10_rx_valid", bus.rx_valid, 0);
        check("abort10_state", dut.state, IDLE);
`ifdef SPI_SLAVE_ERR_EN
        check("abort10_frame_err", bus.frame_err, 1);
`endif
        tick();

        // Asynchronous reset while rx_valid is high.
        bus.SS_n = 1'b0;
        tick();
        send_bits(make_frame(CMD_WR_ADDR, 8'hAB), 10);
        check("pre_reset_rx_valid", bus.rx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rx_valid_drop", bus.rx_valid, 0);
        check("async_rx_data_clear", bus.rx_data, 0);
        bus.SS_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during READ_DATA shift-out.
        bus.SS_n = 1'b0;
        tick();
        exp_q.push_back(make_frame(CMD_RD_ADDR, 8'hAA));
        send_bits(make_frame(CMD_RD_ADDR, 8'hAA), 10);
        end_frame("rst_rd_addr");
        tick();
        bus.SS_n = 1'b0;
        tick();
        exp_q.push_back(make_frame(CMD_RD_DATA, 8'hFF));
        send_bits(make_frame(CMD_RD_DATA, 8'hFF), 10);
        tx_byte      = 8'hA5;
        bus.tx_valid = 1'b1;
        bus.tx_data  = tx_byte;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rd_miso_bit%0d", 7 - i), bus.MISO, tx_byte[7-i]);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_miso", bus.MISO, 0);
        check("rst_rd_rx_valid", bus.rx_valid, 0);
        check("rst_rd_seen", dut.rd_addr_seen, 0);
        check("rst_rd_state", dut.state, IDLE);
        bus.SS_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // After reset a read frame must be treated as an address again.
        bus.SS_n = 1'b0;
        tick();
        exp_q.push_back(make_frame(CMD_RD_ADDR, 8'hC1));
        send_bits(make_frame(CMD_RD_ADDR, 8'hC1), 10);
        check("post_rst_state", dut.state, READ_ADD);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        miso_hi      = 1'b0;
        repeat (3) begin
            tick();
            miso_hi = miso_hi | bus.MISO;
        end
        check("post_rst_miso_quiet", miso_hi, 0);
        check("post_rst_seen", dut.rd_addr_seen, 1);
        bus.tx_valid = 1'b0;
        end_frame("post_rst");
        tick();

        check("rx_missing", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
